// File: rtl/fetch_sequencer_pkg.sv
// Shared core definitions for the instruction fetch sequencer: sequencer
// state encoding and the native instruction width.
package fetch_sequencer_pkg;

  localparam int INSTR_W = 32;

  localparam int STATE_W = 2;
  localparam logic [STATE_W-1:0] ST_IDLE  = 2'd0;
  localparam logic [STATE_W-1:0] ST_RUN   = 2'd1;
  localparam logic [STATE_W-1:0] ST_DRAIN = 2'd2;
  localparam logic [STATE_W-1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/fetch_sequencer_queue.sv
// Small power-of-two FIFO holding {pc, instruction} pairs for the fetch
// sequencer. Supports synchronous flush and simultaneous push/pop. Head
// outputs read straight from storage and are forced to zero while empty.
module fetch_queue #(
  parameter int W     = 32,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic [W-1:0]             push_pc,
  input  logic [W-1:0]             push_instr,
  input  logic                     pop,
  output logic                     out_valid,
  output logic [W-1:0]             out_pc,
  output logic [W-1:0]             out_instr,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [W-1:0]  pc_mem    [DEPTH];
  logic [W-1:0]  instr_mem [DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic          do_push;
  logic          do_pop;

  // A pop in the same cycle frees the slot a full-queue push needs.
  assign do_pop    = pop && (count != '0);
  assign do_push   = push && ((count != FULL) || do_pop);

  // Gating with out_valid keeps the head outputs at zero after reset
  // without having to clear the storage.
  assign out_valid = (count != '0);
  assign out_pc    = out_valid ? pc_mem[head]    : '0;
  assign out_instr = out_valid ? instr_mem[head] : '0;

  // Entry storage: written at the tail on every accepted push.
  // NOTE: storage has no reset; validity is tracked by count, so clearing it would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      pc_mem[tail]    <= push_pc;
      instr_mem[tail] <= push_instr;
    end
  end

  // Pointer and occupancy bookkeeping; flush empties the queue in one cycle.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (do_push) tail <= tail + 1'b1;
      if (do_pop)  head <= head + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: walks a ROM from PC 0 in 4-byte steps,
// buffers responses in a small queue for a valid/ready consumer, and
// honours branch redirects by flushing queued and inflight work.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int XLEN      = INSTR_W,
  parameter int QDEPTH    = 2,
  parameter int ROM_BYTES = 1024
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [XLEN-1:0] rom_size,
  output logic            fetch_req,
  output logic [XLEN-1:0] fetch_pc,
  input  logic [XLEN-1:0] fetch_instr,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic            busy,
  output logic            done
);

  localparam int CW = $clog2(QDEPTH) + 1;
  localparam logic [CW:0]      QD      = (CW+1)'(QDEPTH);
  localparam logic [XLEN-1:0]  ROM_MAX = XLEN'(ROM_BYTES);

  logic [STATE_W-1:0] state;
  logic [XLEN-1:0]    next_pc;
  logic [XLEN-1:0]    rom_size_q;
  logic [XLEN-1:0]    inflight_pc;
  logic               inflight;
  logic [CW-1:0]      count;

  logic               redirect_act;
  logic               start_act;
  logic               pop;
  logic               push;
  logic               flush;
  logic [CW:0]        occupancy;
  logic [XLEN:0]      pc_plus4;
  logic               last_fetch;
  logic [XLEN-1:0]    redirect_aligned;
  logic [XLEN-1:0]    rom_size_clamped;

  assign redirect_act     = redirect_valid && (state == ST_RUN || state == ST_DRAIN);
  assign start_act        = start && (state == ST_IDLE || state == ST_DONE);
  assign redirect_aligned = redirect_pc & ~XLEN'(3);
  assign rom_size_clamped = (rom_size > ROM_MAX) ? ROM_MAX : rom_size;

  // Slots already promised to an inflight response count as occupied; a
  // pop this cycle frees one, which keeps a depth-2 queue streaming.
  assign pop       = out_valid && out_ready;
  assign occupancy = {1'b0, count} + {{CW{1'b0}}, inflight} - {{CW{1'b0}}, pop};

  // Extra top bit keeps the end-of-program compare honest near 2^XLEN.
  assign pc_plus4   = {1'b0, next_pc} + (XLEN+1)'(4);
  assign last_fetch = pc_plus4 >= {1'b0, rom_size_q};

  assign fetch_req = (state == ST_RUN) && (occupancy < QD) && !redirect_valid;
  assign fetch_pc  = next_pc;

  // The response for last cycle's fetch is dropped if a redirect lands now.
  assign push  = inflight && !redirect_act;
  assign flush = redirect_act || start_act;

  assign busy = (state == ST_RUN) || (state == ST_DRAIN);
  assign done = (state == ST_DONE);

  fetch_queue #(
    .W     (XLEN),
    .DEPTH (QDEPTH)
  ) u_queue (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .push       (push),
    .push_pc    (inflight_pc),
    .push_instr (fetch_instr),
    .pop        (pop),
    .out_valid  (out_valid),
    .out_pc     (out_pc),
    .out_instr  (out_instr),
    .count      (count)
  );

  // Track the one response that can be in flight and remember its PC.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else begin
      inflight    <= fetch_req;
      inflight_pc <= next_pc;
    end
  end

  // Sequencer state, fetch pointer and latched program size.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      next_pc    <= '0;
      rom_size_q <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            rom_size_q <= rom_size_clamped;
            next_pc    <= '0;
            state      <= ST_RUN;
          end
        end
        ST_RUN, ST_DRAIN: begin
          if (redirect_valid) begin
            next_pc <= redirect_aligned;
            state   <= (redirect_aligned < rom_size_q) ? ST_RUN : ST_DONE;
          end else if (fetch_req) begin
            next_pc <= pc_plus4[XLEN-1:0];
            if (last_fetch) state <= ST_DRAIN;
          end else if (state == ST_DRAIN && count == '0 && !inflight) begin
            state <= ST_DONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: a table of whole-program runs
// followed by hand-written sequences for start latency, backpressure,
// redirects, restart and asynchronous reset.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] rom_size;
  logic        fetch_req;
  logic [31:0] fetch_pc;
  logic [31:0] fetch_instr = 32'h0;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [31:0] fetch_log [$];
  logic [31:0] acc_pc    [$];
  logic [31:0] acc_instr [$];
  int          acc_cyc   [$];

  typedef struct {
    logic [31:0] rom;
    bit          toggle;
    int          exp_n;
    bit          b2b;
  } vec_t;

  vec_t vecs [7];

  fetch_sequencer #(
    .XLEN      (32),
    .QDEPTH    (2),
    .ROM_BYTES (1024)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .rom_size       (rom_size),
    .fetch_req      (fetch_req),
    .fetch_pc       (fetch_pc),
    .fetch_instr    (fetch_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .busy           (busy),
    .done           (done)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [31:0] pc);
    return 32'hC0DE_0000 ^ pc;
  endfunction

  // ROM: data for a request appears exactly one cycle later.
  always @(posedge clk) fetch_instr <= fetch_req ? rom_word(fetch_pc) : 32'hDEAD_BEEF;

  // Monitor: log issued fetches and accepted head entries mid-cycle.
  always @(negedge clk) begin
    cyc++;
    if (fetch_req) fetch_log.push_back(fetch_pc);
    if (out_valid && out_ready) begin
      acc_pc.push_back(out_pc);
      acc_instr.push_back(out_instr);
      acc_cyc.push_back(cyc);
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pulse_start(input logic [31:0] r);
    @(posedge clk); #1;
    rom_size = r;
    start    = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic run_until_done(input bit toggle, input string tag);
    bit ok = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      @(posedge clk); #1;
      if (done) begin
        ok = 1'b1;
        break;
      end
      if (toggle) out_ready = ~out_ready;
    end
    check(tag, 64'(ok), 64'd1);
  endtask

  // Count accepted entries since base that are not 0,4,8,... with matching data.
  function automatic int seq_errors(input int ab, input int n, input logic [31:0] first_pc);
    int bad = 0;
    for (int i = 0; i < n; i++) begin
      logic [31:0] pc = first_pc + 32'(4 * i);
      if (ab + i >= acc_pc.size()) begin
        bad++;
      end else if (acc_pc[ab+i] !== pc || acc_instr[ab+i] !== rom_word(pc)) begin
        bad++;
      end
    end
    return bad;
  endfunction

  initial begin
    int fb;
    int ab;
    int bad;
    bit stable;

    vecs[0] = '{rom: 32'd16,   toggle: 1'b0, exp_n: 4,   b2b: 1'b1};
    vecs[1] = '{rom: 32'd4,    toggle: 1'b0, exp_n: 1,   b2b: 1'b1};
    vecs[2] = '{rom: 32'd6,    toggle: 1'b0, exp_n: 2,   b2b: 1'b1};
    vecs[3] = '{rom: 32'd20,   toggle: 1'b1, exp_n: 5,   b2b: 1'b0};
    vecs[4] = '{rom: 32'd1027, toggle: 1'b0, exp_n: 256, b2b: 1'b1};
    vecs[5] = '{rom: 32'd13,   toggle: 1'b1, exp_n: 4,   b2b: 1'b0};
    vecs[6] = '{rom: 32'd1024, toggle: 1'b0, exp_n: 256, b2b: 1'b1};

    reset          = 1'b1;
    start          = 1'b0;
    rom_size       = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    out_ready      = 1'b0;

    // Reset values, before any clock edge.
    #1;
    check("rst_fetch_req", 64'(fetch_req), 64'd0);
    check("rst_fetch_pc",  64'(fetch_pc),  64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_instr", 64'(out_instr), 64'd0);
    check("rst_out_pc",    64'(out_pc),    64'd0);
    check("rst_busy",      64'(busy),      64'd0);
    check("rst_done",      64'(done),      64'd0);
    step(); step();
    reset = 1'b0;
    step();
    check("idle_busy", 64'(busy), 64'd0);

    // Whole-program runs from the table.
    for (int v = 0; v < 7; v++) begin
      fb = fetch_log.size();
      ab = acc_pc.size();
      out_ready = 1'b1;
      pulse_start(vecs[v].rom);
      run_until_done(vecs[v].toggle, $sformatf("v%0d_done", v));
      check($sformatf("v%0d_n_acc", v),   64'(acc_pc.size() - ab),    64'(vecs[v].exp_n));
      check($sformatf("v%0d_n_fetch", v), 64'(fetch_log.size() - fb), 64'(vecs[v].exp_n));
      check($sformatf("v%0d_order", v),   64'(seq_errors(ab, vecs[v].exp_n, 32'h0)), 64'd0);
      bad = 0;
      for (int i = 0; i < vecs[v].exp_n && fb + i < fetch_log.size(); i++) begin
        if (fetch_log[fb+i] !== 32'(4 * i)) bad++;
      end
      check($sformatf("v%0d_fetch_pcs", v), 64'(bad), 64'd0);
      if (vecs[v].b2b) begin
        bad = 0;
        for (int i = 1; i < vecs[v].exp_n && ab + i < acc_cyc.size(); i++) begin
          if (acc_cyc[ab+i] - acc_cyc[ab+i-1] != 1) bad++;
        end
        check($sformatf("v%0d_b2b", v), 64'(bad), 64'd0);
      end
      check($sformatf("v%0d_busy", v),  64'(busy),      64'd0);
      check($sformatf("v%0d_valid", v), 64'(out_valid), 64'd0);
    end

    // First-instruction latency, then backpressure for 10 cycles.
    fb = fetch_log.size();
    ab = acc_pc.size();
    out_ready = 1'b0;
    pulse_start(32'd16);
    step();
    check("lat_valid_e1", 64'(out_valid), 64'd0);
    step();
    check("lat_valid_e2", 64'(out_valid), 64'd1);
    check("lat_pc_e2",    64'(out_pc),    64'd0);
    check("lat_instr_e2", 64'(out_instr), 64'(rom_word(32'h0)));
    stable = 1'b1;
    for (int c = 0; c < 8; c++) begin
      step();
      if (!out_valid || out_pc !== 32'h0 || out_instr !== rom_word(32'h0)) stable = 1'b0;
    end
    check("bp_fetches", 64'(fetch_log.size() - fb), 64'd2);
    check("bp_stable",  64'(stable), 64'd1);
    out_ready = 1'b1;
    run_until_done(1'b0, "bp_done");
    check("bp_n_acc", 64'(acc_pc.size() - ab), 64'd4);
    check("bp_order", 64'(seq_errors(ab, 4, 32'h0)), 64'd0);
    check("bp_n_fetch", 64'(fetch_log.size() - fb), 64'd4);

    // Redirect while one entry is queued and one response is inflight.
    fb = fetch_log.size();
    ab = acc_pc.size();
    out_ready = 1'b0;
    pulse_start(32'd64);
    step();
    step();
    check("rd_pre_valid", 64'(out_valid), 64'd1);
    check("rd_pre_pc",    64'(out_pc),    64'd0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h22;
    @(negedge clk);
    check("rd_no_fetch", 64'(fetch_req), 64'd0);
    step();
    redirect_valid = 1'b0;
    check("rd_flushed", 64'(out_valid), 64'd0);
    @(negedge clk);
    check("rd_fetch_req", 64'(fetch_req), 64'd1);
    check("rd_fetch_pc",  64'(fetch_pc),  64'h20);
    step();
    check("rd_squashed", 64'(out_valid), 64'd0);
    step();
    check("rd_head_valid", 64'(out_valid), 64'd1);
    check("rd_head_pc",    64'(out_pc),    64'h20);
    out_ready = 1'b1;
    run_until_done(1'b0, "rd_done");
    check("rd_n_acc",   64'(acc_pc.size() - ab), 64'd8);
    check("rd_order",   64'(seq_errors(ab, 8, 32'h20)), 64'd0);
    check("rd_n_fetch", 64'(fetch_log.size() - fb), 64'd10);

    // Redirect past the end of the program goes straight to DONE.
    fb = fetch_log.size();
    out_ready = 1'b1;
    pulse_start(32'd64);
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h400;
    @(negedge clk);
    check("oob_no_fetch", 64'(fetch_req), 64'd0);
    step();
    redirect_valid = 1'b0;
    check("oob_done",  64'(done),      64'd1);
    check("oob_valid", 64'(out_valid), 64'd0);
    check("oob_busy",  64'(busy),      64'd0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0;
    step();
    redirect_valid = 1'b0;
    step();
    check("oob_redirect_in_done", 64'(done),      64'd1);
    check("oob_valid_later",      64'(out_valid), 64'd0);
    check("oob_n_fetch", 64'(fetch_log.size() - fb), 64'd1);

    // Start during RUN is ignored; a start in DONE restarts from PC 0.
    ab = acc_pc.size();
    out_ready = 1'b1;
    pulse_start(32'd64);
    step();
    rom_size = 32'd8;
    start    = 1'b1;
    step();
    start    = 1'b0;
    run_until_done(1'b0, "ign_done");
    check("ign_n_acc", 64'(acc_pc.size() - ab), 64'd16);
    check("ign_order", 64'(seq_errors(ab, 16, 32'h0)), 64'd0);
    ab = acc_pc.size();
    pulse_start(32'd8);
    run_until_done(1'b0, "rs_done");
    check("rs_n_acc", 64'(acc_pc.size() - ab), 64'd2);
    check("rs_order", 64'(seq_errors(ab, 2, 32'h0)), 64'd0);

    // Asynchronous reset in RUN with two entries queued.
    out_ready = 1'b0;
    pulse_start(32'd64);
    step();
    step();
    step();
    check("ar_busy_pre",  64'(busy),      64'd1);
    check("ar_valid_pre", 64'(out_valid), 64'd1);
    #3;
    reset = 1'b1;
    #1;
    check("ar_fetch_req", 64'(fetch_req), 64'd0);
    check("ar_fetch_pc",  64'(fetch_pc),  64'd0);
    check("ar_out_valid", 64'(out_valid), 64'd0);
    check("ar_out_instr", 64'(out_instr), 64'd0);
    check("ar_out_pc",    64'(out_pc),    64'd0);
    check("ar_busy",      64'(busy),      64'd0);
    check("ar_done",      64'(done),      64'd0);
    step();
    reset = 1'b0;
    fb = fetch_log.size();
    out_ready = 1'b1;
    step(); step(); step();
    check("ar_post_valid", 64'(out_valid), 64'd0);
    check("ar_post_busy",  64'(busy),      64'd0);
    check("ar_post_done",  64'(done),      64'd0);
    check("ar_post_fetch", 64'(fetch_log.size() - fb), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
